// File: rtl/alu_pkg.sv
// Shared ALU types: opcode enum, flag bit positions and flag vector width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

   localparam int FLAG_W = 4;

   // Bit positions inside flags = {carry, overflow, negative, zero}
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_C = 3;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_NOT = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7,
      OP_SRA = 4'd8,
      OP_MUL = 4'd9,
      OP_CMP = 4'd10
   } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: a, b, op -> result, flags, err. MUL only when ALU_MUL_EN is defined.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]  a_i,
   input  logic [WIDTH-1:0]  b_i,
   input  alu_op_t           op_i,
   output logic [WIDTH-1:0]  result_o,
   output logic [FLAG_W-1:0] flags_o,
   output logic              err_o
);

   localparam int SW = $clog2(WIDTH);

   logic [SW-1:0]    sh;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   shl_ext;
   logic [WIDTH-1:0] res;
   logic             c;
   logic             v;
   logic             legal;
`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] prod;
   assign prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
`endif

   // Only the low bits of b select the shift distance.
   assign sh      = b_i[SW-1:0];
   assign sum     = {1'b0, a_i} + {1'b0, b_i};
   // Top bit of the extended difference is the unsigned borrow.
   assign diff    = {1'b0, a_i} - {1'b0, b_i};
   // Extended left shift: bit WIDTH holds the last bit shifted out (0 when sh==0).
   assign shl_ext = {1'b0, a_i} << sh;

   // Select the operation result and carry/overflow, then derive zero/negative.
   always_comb begin
      res   = '0;
      c     = 1'b0;
      v     = 1'b0;
      legal = 1'b1;
      case (op_i)
         OP_ADD: begin
            res = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            res = (op_i == OP_SUB) ? diff[WIDTH-1:0] : '0;
            c   = diff[WIDTH];
            v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_AND: res = a_i & b_i;
         OP_OR:  res = a_i | b_i;
         OP_XOR: res = a_i ^ b_i;
         OP_NOT: res = ~a_i;
         OP_SHL: begin
            res = shl_ext[WIDTH-1:0];
            c   = shl_ext[WIDTH];
         end
         OP_SHR: res = a_i >> sh;
         OP_SRA: res = $signed(a_i) >>> sh;
`ifdef ALU_MUL_EN
         OP_MUL: begin
            res = prod[WIDTH-1:0];
            c   = |prod[2*WIDTH-1:WIDTH];
         end
`endif
         default: legal = 1'b0;
      endcase

      flags_o = '0;
      if (legal) begin
         flags_o[FLAG_C] = c;
         flags_o[FLAG_V] = v;
         flags_o[FLAG_N] = (op_i == OP_CMP) ? diff[WIDTH-1] : res[WIDTH-1];
         flags_o[FLAG_Z] = (op_i == OP_CMP) ? (a_i == b_i) : (res == '0);
      end
      result_o = res;
      err_o    = !legal;
   end

endmodule

// File: rtl/alu_pipelined.sv
// Two-stage ALU pipeline (operand regs -> result regs) around alu_core; MUL enabled by ALU_MUL_EN.
// Latency: out_valid exactly 2 cycles after the input transfer; one result per cycle when unstalled.
// Backpressure: valid/ready; in_ready = !s1_valid || s2_free, outputs hold while out_ready is low.
module alu_pipelined
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  alu_op_t           op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic [FLAG_W-1:0] flags,
   output logic              err
);

   logic              s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]  s1_a_q, s1_a_d;
   logic [WIDTH-1:0]  s1_b_q, s1_b_d;
   alu_op_t           s1_op_q, s1_op_d;

   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              err_q, err_d;

   logic              s2_free;
   logic [WIDTH-1:0]  core_result;
   logic [FLAG_W-1:0] core_flags;
   logic              core_err;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a_i      (s1_a_q),
      .b_i      (s1_b_q),
      .op_i     (s1_op_q),
      .result_o (core_result),
      .flags_o  (core_flags),
      .err_o    (core_err)
   );

   // Ready chain: stage 2 frees when drained, stage 1 accepts when empty or moving on.
   always_comb begin
      s2_free  = !out_valid_q || out_ready;
      in_ready = !s1_valid_q || s2_free;
   end

   // Next-state for both stages; payload only captured alongside a valid token.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_op_d     = s1_op_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      err_d       = err_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d  = a;
            s1_b_d  = b;
            s1_op_d = op;
         end
      end
      if (s2_free) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d = core_result;
            flags_d  = core_flags;
            err_d    = core_err;
         end
      end
   end

   // Pipeline registers; reset drops all in-flight tokens.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= OP_ADD;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_pipelined.sv
// Scoreboard bench for alu_pipelined (WIDTH=8) with directed, hand-computed vectors.
// Latency: checks 2-cycle transfer-to-out_valid on isolated requests.
// Backpressure: drives an out_ready stall window and checks hold/order/no-loss.
module tb_alu_pipelined;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   alu_op_t    op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic [3:0] flags;
   logic       err;

   alu_pipelined #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] res;
      logic [3:0] flg;
      logic       err;
      int         cyc;
      bit         lat;
      int         id;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   next_id = 0;
   bit   saw_stall = 0;
   bit   held_vld = 0;
   logic [7:0] held_res;
   logic [3:0] held_flg;
   logic       held_err;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (id %0d): got %0h, expected %0h", name, id, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every output transfer; checks hold while stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         held_vld = 0;
      end else begin
         if (in_valid && !in_ready) saw_stall = 1;
         if (out_valid && !out_ready) begin
            if (held_vld) begin
               check("hold_result", -1, result, held_res);
               check("hold_flags", -1, flags, held_flg);
               check("hold_err", -1, err, held_err);
            end
            held_vld = 1;
            held_res = result;
            held_flg = flags;
            held_err = err;
         end else begin
            held_vld = 0;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", -1, 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result", e.id, result, e.res);
               check("flags", e.id, flags, e.flg);
               check("err", e.id, err, e.err);
               if (e.lat) check("latency", e.id, cyc - e.cyc, 2);
            end
         end
      end
   end

   // Present one request and hold it until it transfers; expected response goes to the scoreboard.
   task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] top,
                       input logic [7:0] er, input logic [3:0] ef, input logic ee, input bit lat);
      exp_t e;
      a        = ta;
      b        = tb_;
      op       = alu_op_t'(top);
      in_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.res = er; e.flg = ef; e.err = ee; e.cyc = cyc; e.lat = lat; e.id = next_id;
            next_id++;
            sb.push_back(e);
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      check("send_timeout", next_id, 1, 0);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      op        = OP_ADD;
      #2;
      check("rst_out_valid", -1, out_valid, 0);
      check("rst_in_ready", -1, in_ready, 1);
      check("rst_result", -1, result, 0);
      check("rst_flags", -1, flags, 0);
      check("rst_err", -1, err, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Isolated directed vectors: {C,V,N,Z} flags, latency checked.
      send(8'hFF, 8'h01, 4'd0,  8'h00, 4'b1001, 1'b0, 1); idle(3); // ADD wrap
      send(8'h7F, 8'h01, 4'd0,  8'h80, 4'b0110, 1'b0, 1); idle(3); // ADD signed overflow
      send(8'h03, 8'h05, 4'd1,  8'hFE, 4'b1010, 1'b0, 1); idle(3); // SUB borrow
      send(8'h55, 8'h66, 4'd12, 8'h00, 4'b0000, 1'b1, 1); idle(3); // illegal opcode
`ifdef ALU_MUL_EN
      send(8'h10, 8'h10, 4'd9,  8'h00, 4'b1001, 1'b0, 1); idle(3); // MUL high bits set
`else
      send(8'h10, 8'h10, 4'd9,  8'h00, 4'b0000, 1'b1, 1); idle(3); // MUL not built
`endif
      send(8'h81, 8'h01, 4'd6,  8'h02, 4'b1000, 1'b0, 1); idle(3); // SHL carry out
      send(8'h80, 8'h03, 4'd8,  8'hF0, 4'b0010, 1'b0, 1); idle(3); // SRA sign fill
      send(8'h01, 8'h09, 4'd6,  8'h02, 4'b0000, 1'b0, 1); idle(3); // SHL upper b ignored
      send(8'h05, 8'h05, 4'd10, 8'h00, 4'b0001, 1'b0, 1); idle(3); // CMP equal
      send(8'h00, 8'h00, 4'd15, 8'h00, 4'b0000, 1'b1, 1); idle(3); // top illegal opcode

      // Back-to-back stream of 10 with out_ready low for cycles 3..6.
      fork
         begin
            send(8'h05, 8'h03, 4'd0,  8'h08, 4'b0000, 1'b0, 0);
            send(8'h05, 8'h05, 4'd1,  8'h00, 4'b0001, 1'b0, 0);
            send(8'hF0, 8'h3C, 4'd2,  8'h30, 4'b0000, 1'b0, 0);
            send(8'hF0, 8'h0F, 4'd3,  8'hFF, 4'b0010, 1'b0, 0);
            send(8'hAA, 8'hFF, 4'd4,  8'h55, 4'b0000, 1'b0, 0);
            send(8'h0F, 8'h00, 4'd5,  8'hF0, 4'b0010, 1'b0, 0);
            send(8'h80, 8'h04, 4'd7,  8'h08, 4'b0000, 1'b0, 0);
            send(8'h03, 8'h05, 4'd10, 8'h00, 4'b1010, 1'b0, 0);
            send(8'h80, 8'h80, 4'd0,  8'h00, 4'b1101, 1'b0, 0);
            send(8'h80, 8'h01, 4'd1,  8'h7F, 4'b0100, 1'b0, 0);
            in_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 12; k++) begin
               out_ready = !(k >= 3 && k <= 6);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      idle(6);
      check("stream_in_ready_dropped", -1, saw_stall, 1);
      check("stream_drained", -1, sb.size(), 0);

      // Reset with two requests in flight.
      send(8'h01, 8'h02, 4'd0, 8'h03, 4'b0000, 1'b0, 0);
      send(8'h04, 8'h05, 4'd0, 8'h09, 4'b0000, 1'b0, 0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst_out_valid", -1, out_valid, 0);
      check("midrst_in_ready", -1, in_ready, 1);
      check("midrst_result", -1, result, 0);
      check("midrst_flags", -1, flags, 0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(5);
      send(8'hFF, 8'h01, 4'd0, 8'h00, 4'b1001, 1'b0, 1);
      idle(1);

      for (int t = 0; t < 100 && sb.size() > 0; t++) @(posedge clk);
      #1;
      check("final_drain", -1, sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_pipelined.md
ALU_PIPELINED -- requirements
Module: alu_pipelined

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 4..32.
REQ-002 clk  input  1: single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1: asynchronous, active-low reset.
REQ-004 in_valid  input  1: the operand and opcode fields carry a request.
REQ-005 in_ready  output  1: the block accepts a request this cycle.
REQ-006 a  input  WIDTH: operand A.
REQ-007 b  input  WIDTH: operand B.
REQ-008 op  input  4: opcode of type alu_op_t.
REQ-009 out_valid  output  1: result and flags are valid.
REQ-010 out_ready  input  1: the consumer accepts the result this cycle.
REQ-011 result  output  WIDTH: operation result.
REQ-012 flags  output  4: {carry, overflow, negative, zero}.
REQ-013 err  output  1: the opcode was illegal or is not compiled in.

Function
REQ-014 A request transfers when in_valid && in_ready; a response transfers when out_valid && out_ready.
REQ-015 Pipeline: stage 1 registers the operands and opcode; stage 2 registers result, flags and err; latency from input transfer to out_valid is exactly 2 cycles.
REQ-016 in_ready = !s1_valid || s2_free; s2_free = !out_valid || out_ready (both combinational, no bubble).
REQ-017 With in_valid and out_ready held high, throughput is one result per cycle.
REQ-018 When out_valid is high and out_ready is low, result, flags and err hold stable and no stage advances.
REQ-019 Opcodes are: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5 (~a), SHL=6, SHR=7 (logical), SRA=8, MUL=9, CMP=10 (a-b with flags only, result=0).
REQ-020 Shift amount is b[$clog2(WIDTH)-1:0]; upper bits of b are ignored.
REQ-021 ADD: carry = carry-out of bit WIDTH-1; overflow = signed overflow.
REQ-022 SUB/CMP: carry = borrow (a<b unsigned); overflow = signed overflow.
REQ-023 For logic ops and shifts, carry = 0 and overflow = 0, except that SHL sets carry to the last bit shifted out.
REQ-024 zero = (result==0), or (a==b) for CMP; negative = MSB of the WIDTH-bit difference for CMP, MSB of result otherwise.
REQ-025 Opcodes 11..15 give result=0, flags=0 and err=1; the response is still produced in order.
REQ-026 Responses complete strictly in request order; no request is lost or duplicated under any valid/ready pattern.

Reset
REQ-027 When rst_n is low: s1_valid=0, out_valid=0, result=0, flags=0, err=0, in_ready=1 (asynchronously).
REQ-028 A reset asserted mid-operation discards all in-flight requests; the first request after rst_n rises completes 2 cycles after its transfer.

Configuration
REQ-029 Macro ALU_MUL_EN defined: MUL returns the low WIDTH bits of the unsigned a*b; carry=1 if any high product bit is nonzero; err=0.
REQ-030 ALU_MUL_EN undefined: no multiplier is synthesised; MUL behaves as an illegal opcode (result=0, flags=0, err=1).

Structure
REQ-031 Package alu_pkg holds the alu_op_t enum (4-bit), the flag bit-index constants and the FLAG_W=4 constant.
REQ-032 Combinational datapath in sub-module alu_core (a, b, op -> result, flags, err); alu_pipelined holds the pipeline registers and handshake only.

Verification (WIDTH=8, ALU_MUL_EN defined unless stated)
REQ-033 ADD a=8'hFF b=8'h01, out_ready=1 -> 2 cycles later result=8'h00, carry=1, zero=1, overflow=0.
REQ-034 ADD a=8'h7F b=8'h01 -> result=8'h80, overflow=1, negative=1; SUB a=3 b=5 -> result=8'hFE, carry=1.
REQ-035 Back-to-back stream of 10 requests with out_ready low for cycles 3-6 -> in_ready drops when both stages are full, outputs hold stable, all 10 results arrive in order and none is lost.
REQ-036 op=4'd12 -> err=1, result=0, flags=0; MUL 8'h10*8'h10 without ALU_MUL_EN -> err=1; with it -> result=0, carry=1.
REQ-037 rst_n pulsed low while 2 requests are in flight -> out_valid=0 immediately and no stale result appears after release.
REQ-038 SHL a=8'h81 b=8'h01 -> result=8'h02, carry=1; SRA a=8'h80 b=8'h03 -> result=8'hF0.
